// File: rtl/rr_grant_ctrl_if.sv
// Request/grant bundle between requesters and the round-robin grant controller.
// The arbiter side uses the slave modport; requesters use the master modport.
interface rr_grant_ctrl_if #(
  parameter int N = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  i_req;
  logic          i_ack;
  logic [N-1:0]  o_gnt;
  logic [IW-1:0] o_gnt_idx;
  logic          o_gnt_valid;
  logic          o_timeout;

  modport master (
    output i_req,
    output i_ack,
    input  o_gnt,
    input  o_gnt_idx,
    input  o_gnt_valid,
    input  o_timeout
  );

  modport slave (
    input  i_req,
    input  i_ack,
    output o_gnt,
    output o_gnt_idx,
    output o_gnt_valid,
    output o_timeout
  );
endinterface

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: rotating priority pointer, masked/unmasked
// lowest-bit encoders, and a one-hot grant held until ack, withdraw or timeout.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | no grant; arbitrate among i_req on every cycle
//   S_GRANT | one-hot grant held; release on ack, withdraw or hold timeout
module rr_grant_ctrl #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  rr_grant_ctrl_if.slave  bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
  localparam logic [HW-1:0] HOLD_SAT  = (MAX_HOLD > 0) ? HW'(MAX_HOLD) : {HW{1'b1}};
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [HW-1:0] hold_cnt;

  logic [N-1:0]  mask;
  logic [N-1:0]  masked;
  logic [IW-1:0] win_m;
  logic [IW-1:0] win_u;
  logic [IW-1:0] win_idx;
  logic          rel_ack;
  logic          rel_drop;
  logic          rel_to;
  logic          release_now;
  logic [IW-1:0] ptr_next;

  always_comb begin
    mask  = '0;
    win_m = '0;
    win_u = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    masked = bus.i_req & mask;
    // Scan high to low so the last hit is the lowest set bit.
    for (int i = N - 1; i >= 0; i--) begin
      if (masked[i]) win_m = IW'(i);
      if (bus.i_req[i]) win_u = IW'(i);
    end
    win_idx = (|masked) ? win_m : win_u;
  end

  always_comb begin
    rel_ack     = bus.i_ack;
    rel_drop    = ~(|(bus.i_req & bus.o_gnt));
    rel_to      = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    release_now = rel_ack | rel_drop | rel_to;
    ptr_next    = (bus.o_gnt_idx == IDX_LAST) ? '0 : bus.o_gnt_idx + IW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= S_IDLE;
      ptr             <= '0;
      hold_cnt        <= '0;
      bus.o_gnt       <= '0;
      bus.o_gnt_idx   <= '0;
      bus.o_gnt_valid <= 1'b0;
      bus.o_timeout   <= 1'b0;
    end else begin
      bus.o_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|bus.i_req) begin
            state           <= S_GRANT;
            bus.o_gnt       <= N'(1) << win_idx;
            bus.o_gnt_idx   <= win_idx;
            bus.o_gnt_valid <= 1'b1;
            hold_cnt        <= '0;
          end
        end
        S_GRANT: begin
          if (release_now) begin
            state           <= S_IDLE;
            ptr             <= ptr_next;
            bus.o_gnt       <= '0;
            bus.o_gnt_valid <= 1'b0;
            // Ack and withdraw take precedence, so only a pure timeout pulses.
            bus.o_timeout   <= rel_to & ~rel_ack & ~rel_drop;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl: N=4 and N=3 instances, expected grant
// indices queued at stimulus time and popped when a grant appears.
module tb_rr_grant_ctrl;
  logic clk;
  logic rst_n;

  rr_grant_ctrl_if #(.N(4)) bus4();
  rr_grant_ctrl_if #(.N(3)) bus3();

  rr_grant_ctrl #(.N(4), .MAX_HOLD(16)) u4 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus4));
  rr_grant_ctrl #(.N(3), .MAX_HOLD(16)) u3 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus3));

  int n_checks = 0;
  int n_fail   = 0;
  int q4[$];
  int q3[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant4(input int budget, output int cycles);
    int e;
    cycles = 0;
    while (!bus4.o_gnt_valid && cycles < budget) begin
      step();
      cycles++;
    end
    chk("gnt4_valid", 32'(bus4.o_gnt_valid), 32'd1);
    chk("sb4_pending", 32'(q4.size() > 0), 32'd1);
    if (q4.size() > 0) begin
      e = q4.pop_front();
      chk("gnt4_idx", 32'(bus4.o_gnt_idx), 32'(e));
      chk("gnt4_onehot", 32'(bus4.o_gnt), 32'(1) << e);
    end
  endtask

  task automatic wait_grant3(input int budget, output int cycles);
    int e;
    cycles = 0;
    while (!bus3.o_gnt_valid && cycles < budget) begin
      step();
      cycles++;
    end
    chk("gnt3_valid", 32'(bus3.o_gnt_valid), 32'd1);
    chk("sb3_pending", 32'(q3.size() > 0), 32'd1);
    if (q3.size() > 0) begin
      e = q3.pop_front();
      chk("gnt3_idx", 32'(bus3.o_gnt_idx), 32'(e));
      chk("gnt3_onehot", 32'(bus3.o_gnt), 32'(1) << e);
    end
  endtask

  initial begin
    int cyc;
    rst_n      = 1'b0;
    bus4.i_req = '0;
    bus4.i_ack = 1'b0;
    bus3.i_req = '0;
    bus3.i_ack = 1'b0;
    step();
    step();
    chk("rst_gnt", 32'(bus4.o_gnt), 32'd0);
    chk("rst_idx", 32'(bus4.o_gnt_idx), 32'd0);
    chk("rst_valid", 32'(bus4.o_gnt_valid), 32'd0);
    chk("rst_timeout", 32'(bus4.o_timeout), 32'd0);
    rst_n = 1'b1;
    step();

    // All requesting, ack each grant at once: rotation 0,1,2,3,0.
    bus4.i_req = 4'b1111;
    q4.push_back(0); q4.push_back(1); q4.push_back(2); q4.push_back(3); q4.push_back(0);
    for (int k = 0; k < 5; k++) begin
      wait_grant4(10, cyc);
      chk("rot_latency", 32'(cyc), 32'd1);
      bus4.i_ack = 1'b1;
      step();
      bus4.i_ack = 1'b0;
      chk("rot_idle_gap", 32'(bus4.o_gnt_valid), 32'd0);
      chk("rot_no_timeout", 32'(bus4.o_timeout), 32'd0);
    end
    chk("rot_ptr", 32'(u4.ptr), 32'd1);

    // Grant 1 -> ptr=2, then 4'b0011 has an empty masked set and falls back to 0.
    q4.push_back(1);
    wait_grant4(10, cyc);
    bus4.i_ack = 1'b1;
    step();
    bus4.i_ack = 1'b0;
    bus4.i_req = 4'b0011;
    chk("fb_ptr_before", 32'(u4.ptr), 32'd2);
    q4.push_back(0);
    wait_grant4(10, cyc);
    chk("fb_latency", 32'(cyc), 32'd1);
    bus4.i_ack = 1'b1;
    step();
    bus4.i_ack = 1'b0;
    chk("fb_ptr_after", 32'(u4.ptr), 32'd1);
    q4.push_back(1);
    wait_grant4(10, cyc);
    bus4.i_ack = 1'b1;
    step();
    bus4.i_ack = 1'b0;
    bus4.i_req = 4'b0000;
    chk("fb_ptr_final", 32'(u4.ptr), 32'd2);

    // Hold timeout on idx 1: grant drops 16 cycles after it starts.
    step();
    bus4.i_req = 4'b0010;
    q4.push_back(1);
    wait_grant4(10, cyc);
    cyc = 0;
    while (bus4.o_gnt_valid && cyc < 40) begin
      step();
      cyc++;
    end
    chk("to_hold_cycles", 32'(cyc), 32'd16);
    chk("to_pulse", 32'(bus4.o_timeout), 32'd1);
    chk("to_ptr", 32'(u4.ptr), 32'd2);
    bus4.i_req = 4'b0000;
    step();
    chk("to_pulse_end", 32'(bus4.o_timeout), 32'd0);
    chk("to_idle", 32'(bus4.o_gnt_valid), 32'd0);

    // Requester 3 withdraws without ack: release next cycle, no timeout, ptr wraps.
    bus4.i_req = 4'b1000;
    q4.push_back(3);
    wait_grant4(10, cyc);
    bus4.i_req = 4'b0000;
    step();
    chk("wd_valid", 32'(bus4.o_gnt_valid), 32'd0);
    chk("wd_timeout", 32'(bus4.o_timeout), 32'd0);
    chk("wd_ptr", 32'(u4.ptr), 32'd0);

    // Ack on the timeout cycle wins; other requests mid-grant do not disturb it.
    bus4.i_req = 4'b0100;
    q4.push_back(2);
    wait_grant4(10, cyc);
    bus4.i_req = 4'b1111;
    for (int k = 0; k < 15; k++) step();
    chk("ackto_held", 32'(bus4.o_gnt_valid), 32'd1);
    chk("ackto_idx_stable", 32'(bus4.o_gnt_idx), 32'd2);
    bus4.i_ack = 1'b1;
    step();
    bus4.i_ack = 1'b0;
    bus4.i_req = 4'b0000;
    chk("ackto_released", 32'(bus4.o_gnt_valid), 32'd0);
    chk("ackto_no_pulse", 32'(bus4.o_timeout), 32'd0);
    chk("ackto_ptr", 32'(u4.ptr), 32'd3);

    // Ack while idle is ignored.
    bus4.i_ack = 1'b1;
    step();
    bus4.i_ack = 1'b0;
    chk("idle_ack_ptr", 32'(u4.ptr), 32'd3);
    chk("idle_ack_valid", 32'(bus4.o_gnt_valid), 32'd0);

    // Async reset mid-grant drops the grant before the next edge.
    bus4.i_req = 4'b1000;
    q4.push_back(3);
    wait_grant4(10, cyc);
    bus4.i_req = 4'b1111;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(bus4.o_gnt), 32'd0);
    chk("arst_valid", 32'(bus4.o_gnt_valid), 32'd0);
    step();
    rst_n = 1'b1;
    q4.push_back(0);
    wait_grant4(10, cyc);
    chk("arst_latency", 32'(cyc), 32'd1);
    bus4.i_ack = 1'b1;
    step();
    bus4.i_ack = 1'b0;
    bus4.i_req = 4'b0000;

    // N=3: grant 2 then ptr wraps to 0 without relying on overflow.
    bus3.i_req = 3'b100;
    q3.push_back(2);
    wait_grant3(10, cyc);
    bus3.i_ack = 1'b1;
    step();
    bus3.i_ack = 1'b0;
    bus3.i_req = 3'b111;
    chk("n3_ptr_wrap", 32'(u3.ptr), 32'd0);
    q3.push_back(0);
    wait_grant3(10, cyc);
    chk("n3_latency", 32'(cyc), 32'd1);
    bus3.i_ack = 1'b1;
    step();
    bus3.i_ack = 1'b0;
    q3.push_back(1);
    wait_grant3(10, cyc);
    bus3.i_ack = 1'b1;
    step();
    bus3.i_ack = 1'b0;
    bus3.i_req = 3'b000;
    chk("n3_ptr_after1", 32'(u3.ptr), 32'd2);

    chk("sb4_drained", 32'(q4.size()), 32'd0);
    chk("sb3_drained", 32'(q3.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
